// File: rtl/byte_stream_packer_pkg.sv
// ---------------------------------------------------------------------------
// byte_stream_packer_pkg
// Shared constants for the byte-to-word packing path (UART receiver ->
// memory programmer). Kept tiny on purpose: the packer itself is flat and
// carries its own lane-order logic.
// ---------------------------------------------------------------------------
package byte_stream_packer_pkg;

    // Width of one incoming stream element and of one memory lane.
    localparam int BYTE_W = 8;

endpackage : byte_stream_packer_pkg

// File: rtl/byte_stream_packer.sv
// ---------------------------------------------------------------------------
// byte_stream_packer
// Packs a stream of bytes into BYTES_PER_WORD-byte memory words and issues
// one registered write strobe per word, with a self-incrementing word
// address. Supports partial-word flush (unfilled lanes are zero and masked
// off) and address reload (which discards the partial word).
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   byte_valid_in     byte_data_in valid this cycle (no backpressure)
//   byte_data_in      incoming byte
//   flush_in          emit the partially filled word now
//   addr_load_in      load word address from addr_in, drop partial word
//   addr_in           address loaded by addr_load_in
//   word_wr_en_out    one-cycle write strobe
//   word_addr_out     address of the written word (held until next write)
//   word_byte_en_out  valid lanes of the written word (held)
//   word_data_out     packed word (held)
//   addr_wrap_out     one-cycle pulse with the write at the top address
// ---------------------------------------------------------------------------
module byte_stream_packer
    import byte_stream_packer_pkg::*;
#(
    parameter int BYTES_PER_WORD  = 4,
    parameter int WORD_ADDR_WIDTH = 4,
    parameter bit BIG_ENDIAN      = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              byte_valid_in,
    input  logic [BYTE_W-1:0]                 byte_data_in,
    input  logic                              flush_in,
    input  logic                              addr_load_in,
    input  logic [WORD_ADDR_WIDTH-1:0]        addr_in,
    output logic                              word_wr_en_out,
    output logic [WORD_ADDR_WIDTH-1:0]        word_addr_out,
    output logic [BYTES_PER_WORD-1:0]         word_byte_en_out,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]  word_data_out,
    output logic                              addr_wrap_out
);

    localparam int DATA_W = BYTE_W * BYTES_PER_WORD;
    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    // The lane counter only ever holds 0..BYTES_PER_WORD-1: the byte that
    // would take it to BYTES_PER_WORD always triggers a write, which clears it.
    localparam logic [LANE_W-1:0]          LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_TOP  = '1;

    // BYTES_PER_WORD is a power of two, so BYTES_PER_WORD-1-cnt is simply
    // the bitwise complement of cnt within LANE_W bits.
    function automatic logic [LANE_W-1:0] lane_of(input logic [LANE_W-1:0] cnt);
        return BIG_ENDIAN ? ~cnt : cnt;
    endfunction

    // Packing state
    logic [LANE_W-1:0]          lane_cnt_q, lane_cnt_d;
    logic [DATA_W-1:0]          acc_q, acc_d;
    logic [BYTES_PER_WORD-1:0]  mask_q, mask_d;
    logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d;

    // Registered output stage
    logic                       wr_en_q, wr_en_d;
    logic                       wrap_q, wrap_d;
    logic [WORD_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [BYTES_PER_WORD-1:0]  out_be_q, out_be_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;

    // Per-lane write select for the incoming byte
    logic [LANE_W-1:0]          cur_lane;
    logic [BYTES_PER_WORD-1:0]  lane_hit;

    assign cur_lane = lane_of(lane_cnt_q);

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane_hit
            assign lane_hit[gi] = byte_valid_in && (cur_lane == LANE_W'(gi));
        end
    endgenerate

    // Word contents including this cycle's byte, so a byte arriving with a
    // flush (or completing the word) lands in the same single write.
    logic [DATA_W-1:0]         acc_merged;
    logic [BYTES_PER_WORD-1:0] mask_merged;
    logic                      word_full;
    logic                      do_write;

    always_comb begin
        acc_merged  = acc_q;
        mask_merged = mask_q | lane_hit;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane_hit[i]) begin
                acc_merged[i*BYTE_W +: BYTE_W] = byte_data_in;
            end
        end
    end

    assign word_full = byte_valid_in && (lane_cnt_q == LAST_LANE);
    // mask_merged is non-zero exactly when at least one byte is pending.
    assign do_write  = !addr_load_in && (word_full || (flush_in && (|mask_merged)));

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        acc_d      = acc_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wrap_d     = 1'b0;
        out_addr_d = out_addr_q;
        out_be_d   = out_be_q;
        out_data_d = out_data_q;

        if (addr_load_in) begin
            // Reload wins over any byte or flush in the same cycle.
            addr_d     = addr_in;
            lane_cnt_d = '0;
            acc_d      = '0;
            mask_d     = '0;
        end else if (do_write) begin
            wr_en_d    = 1'b1;
            wrap_d     = (addr_q == ADDR_TOP);
            out_addr_d = addr_q;
            out_be_d   = mask_merged;
            out_data_d = acc_merged;
            addr_d     = addr_q + 1'b1;
            lane_cnt_d = '0;
            acc_d      = '0;
            mask_d     = '0;
        end else if (byte_valid_in) begin
            lane_cnt_d = lane_cnt_q + 1'b1;
            acc_d      = acc_merged;
            mask_d     = mask_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q <= '0;
            acc_q      <= '0;
            mask_q     <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wrap_q     <= 1'b0;
            out_addr_q <= '0;
            out_be_q   <= '0;
            out_data_q <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            acc_q      <= acc_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wrap_q     <= wrap_d;
            out_addr_q <= out_addr_d;
            out_be_q   <= out_be_d;
            out_data_q <= out_data_d;
        end
    end

    assign word_wr_en_out   = wr_en_q;
    assign addr_wrap_out    = wrap_q;
    assign word_addr_out    = out_addr_q;
    assign word_byte_en_out = out_be_q;
    assign word_data_out    = out_data_q;

endmodule : byte_stream_packer

// File: tb/tb_byte_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_byte_stream_packer
// Drives one little-endian and one big-endian packer from the same stimulus
// and compares both every cycle against a queue-based model of the packing
// rules, plus literal expectations for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_byte_stream_packer;

    localparam int BPW = 4;
    localparam int AW  = 4;
    localparam int DW  = 8 * BPW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [7:0]    data_i;
    logic          flush_i;
    logic          load_i;
    logic [AW-1:0] ain_i;

    logic           wr_le, wrap_le, wr_be, wrap_be;
    logic [AW-1:0]  addr_le, addr_be;
    logic [BPW-1:0] be_le, be_be;
    logic [DW-1:0]  data_le, data_be;

    always #5 clk = ~clk;

    byte_stream_packer #(.BYTES_PER_WORD(BPW), .WORD_ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst),
        .byte_valid_in(valid_i), .byte_data_in(data_i), .flush_in(flush_i),
        .addr_load_in(load_i), .addr_in(ain_i),
        .word_wr_en_out(wr_le), .word_addr_out(addr_le), .word_byte_en_out(be_le),
        .word_data_out(data_le), .addr_wrap_out(wrap_le)
    );

    byte_stream_packer #(.BYTES_PER_WORD(BPW), .WORD_ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst),
        .byte_valid_in(valid_i), .byte_data_in(data_i), .flush_in(flush_i),
        .addr_load_in(load_i), .addr_in(ain_i),
        .word_wr_en_out(wr_be), .word_addr_out(addr_be), .word_byte_en_out(be_be),
        .word_data_out(data_be), .addr_wrap_out(wrap_be)
    );

    int checks   = 0;
    int failures = 0;
    int writes_seen = 0;

    // Model state: pending bytes in arrival order and the next word address.
    logic [7:0] pend[$];
    int         m_addr = 0;

    logic           exp_wr, exp_wrap;
    logic [AW-1:0]  exp_addr;
    logic [BPW-1:0] exp_be_le, exp_be_be;
    logic [DW-1:0]  exp_data_le, exp_data_be;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_addr      = 0;
        exp_wr      = 0;
        exp_wrap    = 0;
        exp_addr    = '0;
        exp_be_le   = '0;
        exp_be_be   = '0;
        exp_data_le = '0;
        exp_data_be = '0;
    endtask

    // Expected registered outputs after the coming clock edge.
    task automatic model_step(input bit v, input logic [7:0] d, input bit f,
                              input bit l, input logic [AW-1:0] a);
        exp_wr   = 0;
        exp_wrap = 0;
        if (l) begin
            m_addr = int'(a);
            pend.delete();
        end else begin
            if (v) pend.push_back(d);
            if (pend.size() == BPW || (f && pend.size() > 0)) begin
                exp_data_le = '0; exp_be_le = '0;
                exp_data_be = '0; exp_be_be = '0;
                for (int i = 0; i < pend.size(); i++) begin
                    exp_data_le[8*i +: 8]         = pend[i];
                    exp_be_le[i]                  = 1'b1;
                    exp_data_be[8*(BPW-1-i) +: 8] = pend[i];
                    exp_be_be[BPW-1-i]            = 1'b1;
                end
                exp_addr = AW'(m_addr);
                exp_wrap = (m_addr == (1 << AW) - 1);
                exp_wr   = 1;
                m_addr   = (m_addr + 1) % (1 << AW);
                pend.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("le_wr_en",  64'(wr_le),   64'(exp_wr));
        chk("le_wrap",   64'(wrap_le), 64'(exp_wrap));
        chk("le_addr",   64'(addr_le), 64'(exp_addr));
        chk("le_byte_en",64'(be_le),   64'(exp_be_le));
        chk("le_data",   64'(data_le), 64'(exp_data_le));
        chk("be_wr_en",  64'(wr_be),   64'(exp_wr));
        chk("be_wrap",   64'(wrap_be), 64'(exp_wrap));
        chk("be_addr",   64'(addr_be), 64'(exp_addr));
        chk("be_byte_en",64'(be_be),   64'(exp_be_be));
        chk("be_data",   64'(data_be), 64'(exp_data_be));
        if (wr_le) begin
            writes_seen++;
            $display("write addr=%0d be=%b data_le=%08h data_be=%08h wrap=%0b",
                     addr_le, be_le, data_le, data_be, wrap_le);
        end
    endtask

    // One clock cycle: drive inputs, advance model, sample after the edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit f,
                         input bit l, input logic [AW-1:0] a);
        valid_i = v; data_i = d; flush_i = f; load_i = l; ain_i = a;
        model_step(v, d, f, l, a);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(0, 8'h00, 0, 0, '0);
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cycle(1, w[8*i +: 8], 0, 0, '0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset();
        valid_i = 0; flush_i = 0; load_i = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_wr_en", 64'(wr_le),   64'd0);
        chk("rst_addr",  64'(addr_le), 64'd0);
        chk("rst_be",    64'(be_le),   64'd0);
        chk("rst_data",  64'(data_le), 64'd0);
        chk("rst_wrap",  64'(wrap_le), 64'd0);
        chk("rst_be_data", 64'(data_be), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int base;

    initial begin
        rst = 1'b1;
        valid_i = 0; data_i = '0; flush_i = 0; load_i = 0; ain_i = '0;
        model_reset();
        #2;
        chk("reset_wr_en", 64'(wr_le),   64'd0);
        chk("reset_data",  64'(data_le), 64'd0);
        chk("reset_be",    64'(be_be),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full word, both lane orders, then next address.
        send4(32'h44332211);
        chk("lit_wr",      64'(wr_le),   64'd1);
        chk("lit_addr0",   64'(addr_le), 64'd0);
        chk("lit_be_full", 64'(be_le),   64'hF);
        chk("lit_data_le", 64'(data_le), 64'h44332211);
        chk("lit_data_be", 64'(data_be), 64'h11223344);
        send4(32'h88776655);
        chk("lit_addr1",   64'(addr_le), 64'd1);
        idle();
        chk("lit_strobe_one_cycle", 64'(wr_le), 64'd0);

        // Partial flush.
        async_reset();
        cycle(1, 8'hAA, 0, 0, '0);
        cycle(1, 8'hBB, 0, 0, '0);
        cycle(0, 8'h00, 1, 0, '0);
        chk("lit_pflush_wr",   64'(wr_le),   64'd1);
        chk("lit_pflush_data", 64'(data_le), 64'h0000BBAA);
        chk("lit_pflush_be",   64'(be_le),   64'b0011);
        chk("lit_pflush_bedata", 64'(data_be), 64'hAABB0000);
        chk("lit_pflush_bebe", 64'(be_be),   64'b1100);
        chk("lit_pflush_addr", 64'(addr_le), 64'd0);
        send4(32'hDDCCBBAA);
        chk("lit_after_flush_addr", 64'(addr_le), 64'd1);

        // Flush together with the completing byte: exactly one write.
        base = writes_seen;
        cycle(1, 8'h01, 0, 0, '0);
        cycle(1, 8'h02, 0, 0, '0);
        cycle(1, 8'h03, 0, 0, '0);
        cycle(1, 8'h04, 1, 0, '0);
        idle();
        idle();
        chk("lit_flush4_writes", 64'(writes_seen - base), 64'd1);

        // Flush when empty: no write.
        cycle(0, 8'h00, 1, 0, '0);
        chk("lit_empty_flush", 64'(wr_le), 64'd0);

        // Address load discards partial word; wrap at top address.
        cycle(1, 8'h55, 0, 0, '0);
        cycle(1, 8'h66, 0, 0, '0);
        cycle(1, 8'h77, 1, 1, 4'd15);
        chk("lit_load_nowrite", 64'(wr_le), 64'd0);
        send4(32'hA4A3A2A1);
        chk("lit_load_addr",  64'(addr_le), 64'd15);
        chk("lit_load_wrap",  64'(wrap_le), 64'd1);
        chk("lit_load_data",  64'(data_le), 64'hA4A3A2A1);
        send4(32'hB4B3B2B1);
        chk("lit_wrapped_addr", 64'(addr_le), 64'd0);
        chk("lit_wrapped_pulse", 64'(wrap_le), 64'd0);

        // Reset mid-word.
        cycle(1, 8'h01, 0, 0, '0);
        cycle(1, 8'h02, 0, 0, '0);
        cycle(1, 8'h03, 0, 0, '0);
        async_reset();
        send4(32'hC4C3C2C1);
        chk("lit_post_rst_addr", 64'(addr_le), 64'd0);
        chk("lit_post_rst_data", 64'(data_le), 64'hC4C3C2C1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 70, 8'($urandom),
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
                  AW'($urandom));
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_byte_stream_packer
